// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: handshake bundle for bin2bcd_seq
// master (producer/consumer side): drives in_valid, in_data, out_ready
// slave (converter side): drives in_ready, out_valid, out_bcd, overflow, digit_en
interface bin2bcd_seq_if #(parameter int DATA_W = 20, parameter int DIGITS = 6);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  overflow;
  logic [DIGITS-1:0]     digit_en;
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_bcd, overflow, digit_en);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_bcd, overflow, digit_en);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock
// Ports: clk, rst (sync, active-high), bus (bin2bcd_seq_if.slave):
//   in_valid/in_ready/in_data input handshake, out_valid/out_ready/out_bcd/overflow/digit_en result
// Optional macro BCD_BLANK_EN: leading-zero blanking on digit_en (otherwise all ones)
module bin2bcd_seq #(
  parameter int DATA_W = 20,
  parameter int DIGITS = 6
) (
  input logic clk,
  input logic rst,
  bin2bcd_seq_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int W  = BW + DATA_W;
  localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t            state;
  logic [W-1:0]      sr, adj, nxt;
  logic [CW-1:0]     cnt;
  logic              ovf_acc;
  logic [DIGITS-1:0] en_nxt;
  // Add-3 on every BCD digit above 4, then shift the whole {BCD, binary} word
  always_comb begin
    adj = sr;
    for (int k = 0; k < DIGITS; k++)
      adj[DATA_W+4*k +: 4] = sr[DATA_W+4*k +: 4] + (sr[DATA_W+4*k +: 4] > 4'd4 ? 4'd3 : 4'd0);
    nxt = {adj[W-2:0], 1'b0};
  end
`ifdef BCD_BLANK_EN
  // A digit is shown if it or any more significant digit is nonzero; units always shown
  always_comb begin
    logic seen;
    seen = 1'b0;
    en_nxt = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      seen = seen | (|nxt[DATA_W+4*k +: 4]);
      en_nxt[k] = seen | (k == 0);
    end
  end
`else
  assign en_nxt = '1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_bcd   <= '0;
      bus.overflow  <= 1'b0;
      bus.digit_en  <= '1;
      sr            <= '0;
      cnt           <= '0;
      ovf_acc       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sr           <= {{BW{1'b0}}, bus.in_data};
          ovf_acc      <= 1'b0;
          cnt          <= CW'(DATA_W - 1);
          bus.in_ready <= 1'b0;
          state        <= CONV;
        end
        CONV: begin
          sr      <= nxt;
          ovf_acc <= ovf_acc | adj[W-1];
          cnt     <= cnt - CW'(1);
          if (cnt == '0) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_bcd   <= nxt[W-1:DATA_W];
            bus.overflow  <= ovf_acc | adj[W-1];
            bus.digit_en  <= en_nxt;
          end
        end
        DONE: if (bus.out_ready) begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq with an arithmetic reference model
module tb_bin2bcd_seq;
  localparam int DATA_W = 20;
  localparam int DIGITS = 6;
  localparam int BW = 4 * DIGITS;
  typedef struct {
    logic [BW-1:0]     bcd;
    logic              ovf;
    logic [DIGITS-1:0] en;
    int                acc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bp_rand = 1'b0;
  int checks = 0, errors = 0, cyc = 0;
  exp_t sb[$];
  exp_t cur;
  logic shown = 1'b0, busy = 1'b0, post = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bin2bcd_seq_if #(.DATA_W(DATA_W), .DIGITS(DIGITS)) bif();
  bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bif));
  function automatic longint pow10(input int n);
    longint p = 1;
    for (int k = 0; k < n; k++) p *= 10;
    return p;
  endfunction
  // Expected result from plain decimal arithmetic
  function automatic exp_t model(input longint v, input int acc_c);
    exp_t e;
    longint pw = pow10(DIGITS);
    longint m = v % pw;
    longint r = m;
    e.ovf = (v >= pw);
    e.acc = acc_c;
    e.bcd = '0;
    e.en  = '1;
    for (int k = 0; k < DIGITS; k++) begin
      e.bcd[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
`ifdef BCD_BLANK_EN
    for (int k = 0; k < DIGITS; k++) e.en[k] = (k == 0) || (m >= pow10(k));
`endif
    return e;
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  // Monitor: owns the scoreboard, pushes on accept, compares on output
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      shown = 1'b0;
      busy  = 1'b0;
      post  = 1'b0;
    end else begin
      if (post) begin
        chk("idle_after_done", 64'(bif.in_ready), 64'd1);
        post = 1'b0;
      end
      if (busy) chk("in_ready_busy", 64'(bif.in_ready), 64'd0);
      if (bif.out_valid && !shown) begin
        if (sb.size() == 0) chk("spurious_valid", 64'(bif.out_valid), 64'd0);
        else begin
          cur = sb[0];
          chk("latency", 64'(cyc - cur.acc), 64'(DATA_W + 1));
          chk("out_bcd", 64'(bif.out_bcd), 64'(cur.bcd));
          chk("overflow", 64'(bif.overflow), 64'(cur.ovf));
          chk("digit_en", 64'(bif.digit_en), 64'(cur.en));
        end
        shown = 1'b1;
      end else if (bif.out_valid) begin
        chk("hold_bcd", 64'(bif.out_bcd), 64'(cur.bcd));
        chk("hold_ovf", 64'(bif.overflow), 64'(cur.ovf));
      end
      if (bif.out_valid && bif.out_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        shown = 1'b0;
        busy  = 1'b0;
        post  = 1'b1;
      end
      if (bif.in_valid && bif.in_ready) begin
        sb.push_back(model(longint'(bif.in_data), cyc));
        busy = 1'b1;
      end
    end
  end
  always @(posedge clk) if (bp_rand) begin
    #1;
    bif.out_ready = ($urandom_range(0, 3) != 0);
  end
  task automatic wait_ready();
    int t = 0;
    while (!bif.in_ready && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bif.in_ready) chk("in_ready_timeout", 64'(bif.in_ready), 64'd1);
  endtask
  task automatic wait_valid();
    int t = 0;
    while (!bif.out_valid && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bif.out_valid) chk("out_valid_timeout", 64'(bif.out_valid), 64'd1);
  endtask
  task automatic send(input logic [DATA_W-1:0] v);
    @(posedge clk); #1;
    wait_ready();
    bif.in_data  = v;
    bif.in_valid = 1'b1;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
  endtask
  initial begin
    logic [DATA_W-1:0] v;
    int t;
    bif.in_valid  = 1'b0;
    bif.in_data   = '0;
    bif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bif.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
    chk("rst_out_bcd", 64'(bif.out_bcd), 64'd0);
    chk("rst_overflow", 64'(bif.overflow), 64'd0);
    chk("rst_digit_en", 64'(bif.digit_en), 64'({DIGITS{1'b1}}));
    rst = 1'b0;
    send(DATA_W'(123456));
    send(DATA_W'(0));
    send(DATA_W'(999999));
    send(DATA_W'(1048575));
    wait_ready();
    // Back-pressure: result must hold while in_valid/in_data wiggle
    bif.out_ready = 1'b0;
    send(DATA_W'(271828));
    wait_valid();
    repeat (10) begin
      @(posedge clk); #1;
      bif.in_valid = 1'($urandom);
      bif.in_data  = DATA_W'($urandom);
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    wait_ready();
    // Reset in the middle of a conversion
    send(DATA_W'(555555));
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", 64'(bif.in_ready), 64'd1);
    chk("abort_out_valid", 64'(bif.out_valid), 64'd0);
    chk("abort_out_bcd", 64'(bif.out_bcd), 64'd0);
    chk("abort_overflow", 64'(bif.overflow), 64'd0);
    rst = 1'b0;
    repeat (DATA_W + 10) begin
      @(posedge clk); #1;
    end
    chk("abort_no_valid", 64'(bif.out_valid), 64'd0);
    // Randomized values with boundary bias and random consumer stalls
    bp_rand = 1'b1;
    repeat (40) begin
      case ($urandom_range(0, 3))
        0: v = DATA_W'($urandom);
        1: v = '0;
        2: v = '1;
        default: v = DATA_W'(pow10(DIGITS) - 1 + longint'($urandom_range(0, 1)));
      endcase
      send(v);
    end
    @(posedge clk); #1;
    bp_rand = 1'b0;
    @(posedge clk); #1;
    bif.out_ready = 1'b1;
    t = 0;
    while ((sb.size() != 0 || bif.out_valid) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
